// File: rtl/conf_int_mac_pair_sequencer_if.sv
// Stream bundle for the MAC pair sequencer.
// Carries the operand word input stream and the {a, b, d} result record stream.
// The sequencer uses the slave modport; whatever feeds and drains it uses master.
interface conf_int_mac_pair_sequencer_if #(
  parameter int DATA_W = 32
) ();
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_a;
  logic [DATA_W-1:0] out_b;
  logic [DATA_W-1:0] out_d;
  logic              out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_a, out_b, out_d
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_a, out_b, out_d
  );
endinterface

// File: rtl/conf_int_mac_pair_sequencer.sv
// conf_int_mac_pair_sequencer
// Turns a word stream (a, b, a, b, ...) into registered MAC operands, samples
// the MAC result MAC_LAT+1 edges after each issue and queues {a, b, d} records
// in a first-word-fall-through FIFO.
// Issue credit covers FIFO occupancy plus in-flight tokens, so the FIFO never
// overflows and no record is dropped.
// Optional feature: define CONF_INT_MAC_SEQ_STATS_EN to build the 16-bit
// issue/pop statistics counters; otherwise both counter outputs read 0.
module conf_int_mac_pair_sequencer #(
  parameter int DATA_W     = 32,
  parameter int MAC_LAT    = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         racc,
  conf_int_mac_pair_sequencer_if.slave bus,
  output logic [DATA_W-1:0]            mac_a,
  output logic [DATA_W-1:0]            mac_b,
  input  logic [DATA_W-1:0]            mac_d,
  output logic [15:0]                  issue_cnt,
  output logic [15:0]                  rslt_cnt
);

  localparam int STAGES = MAC_LAT + 1;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int SUM_W  = $clog2(FIFO_DEPTH + MAC_LAT + 2);

  typedef enum logic {GET_A, GET_B} state_t;

  state_t            state_reg, state_next;
  logic              in_rdy;
  logic              in_accept;
  logic              issue;
  logic              credit_ok;
  logic [DATA_W-1:0] a_hold_reg;
  logic [DATA_W-1:0] mac_a_reg, mac_b_reg;

  // Issue-token delay line, one entry per stage
  logic [STAGES-1:0] stage_vld;
  logic [DATA_W-1:0] stage_a [STAGES];
  logic [DATA_W-1:0] stage_b [STAGES];
  logic [SUM_W-1:0]  inflight;

  // Result FIFO
  logic [DATA_W-1:0] mem_a [FIFO_DEPTH];
  logic [DATA_W-1:0] mem_b [FIFO_DEPTH];
  logic [DATA_W-1:0] mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [PTR_W-1:0]  head_ptr_next;
  logic [CNT_W-1:0]  count_reg, count_next, count_after_pop;
  logic              push, pop;
  logic [DATA_W-1:0] push_a, push_b;
  logic              out_valid_reg;
  logic [DATA_W-1:0] out_a_reg, out_b_reg, out_d_reg;

  // Next-state and in_ready decode for the two-state pair collector
  always_comb begin
    state_next = state_reg;
    in_rdy     = 1'b0;
    case (state_reg)
      GET_A: begin
        in_rdy = 1'b1;
        if (bus.in_valid) state_next = GET_B;
      end
      GET_B: begin
        in_rdy = credit_ok;
        if (bus.in_valid && credit_ok) state_next = GET_A;
      end
    endcase
  end

  assign bus.in_ready = racc & in_rdy;
  assign in_accept    = bus.in_valid & in_rdy;
  assign issue        = in_accept & (state_reg == GET_B);

  // State register, a-word holding register and the MAC operand registers
  always_ff @(posedge clk or negedge racc) begin
    if (!racc) begin
      state_reg  <= GET_A;
      a_hold_reg <= '0;
      mac_a_reg  <= '0;
      mac_b_reg  <= '0;
    end else begin
      state_reg <= state_next;
      if (in_accept && state_reg == GET_A) a_hold_reg <= bus.in_data;
      if (issue) begin
        mac_a_reg <= a_hold_reg;
        mac_b_reg <= bus.in_data;
      end
    end
  end

  assign mac_a = mac_a_reg;
  assign mac_b = mac_b_reg;

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      logic              vld_reg;
      logic [DATA_W-1:0] a_reg, b_reg;
      if (gi == 0) begin : g_head
        // First stage loads the token of the pair issued on this edge
        always_ff @(posedge clk or negedge racc) begin
          if (!racc) begin
            vld_reg <= 1'b0;
            a_reg   <= '0;
            b_reg   <= '0;
          end else begin
            vld_reg <= issue;
            a_reg   <= a_hold_reg;
            b_reg   <= bus.in_data;
          end
        end
      end else begin : g_tail
        // Later stages shift the token along one per cycle
        always_ff @(posedge clk or negedge racc) begin
          if (!racc) begin
            vld_reg <= 1'b0;
            a_reg   <= '0;
            b_reg   <= '0;
          end else begin
            vld_reg <= stage_vld[gi-1];
            a_reg   <= stage_a[gi-1];
            b_reg   <= stage_b[gi-1];
          end
        end
      end
      assign stage_vld[gi] = vld_reg;
      assign stage_a[gi]   = a_reg;
      assign stage_b[gi]   = b_reg;
    end
  endgenerate

  // Count tokens still waiting for their MAC result
  always_comb begin
    inflight = '0;
    for (int k = 0; k < STAGES; k++) inflight = inflight + SUM_W'(stage_vld[k]);
  end

  // A pop in the same cycle is deliberately not credited
  assign credit_ok = (SUM_W'(count_reg) + inflight) < SUM_W'(FIFO_DEPTH);

  // The token in the last stage meets mac_d on this edge
  assign push   = stage_vld[STAGES-1];
  assign push_a = stage_a[STAGES-1];
  assign push_b = stage_b[STAGES-1];
  assign pop    = out_valid_reg & bus.out_ready;

  assign count_next      = count_reg + CNT_W'(push) - CNT_W'(pop);
  assign count_after_pop = count_reg - CNT_W'(pop);
  assign head_ptr_next   = rd_ptr_reg + PTR_W'(pop);

  // FIFO storage writes (no reset: contents are qualified by count)
  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr_reg] <= push_a;
      mem_b[wr_ptr_reg] <= push_b;
      mem_d[wr_ptr_reg] <= mac_d;
    end
  end

  // FIFO pointers, occupancy and the registered head/output view
  always_ff @(posedge clk or negedge racc) begin
    if (!racc) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      out_valid_reg <= 1'b0;
      out_a_reg     <= '0;
      out_b_reg     <= '0;
      out_d_reg     <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      rd_ptr_reg    <= head_ptr_next;
      count_reg     <= count_next;
      out_valid_reg <= (count_next != '0);
      // When empty the outputs keep the last popped record
      if (count_next != '0) begin
        if (count_after_pop == '0) begin
          out_a_reg <= push_a;
          out_b_reg <= push_b;
          out_d_reg <= mac_d;
        end else begin
          out_a_reg <= mem_a[head_ptr_next];
          out_b_reg <= mem_b[head_ptr_next];
          out_d_reg <= mem_d[head_ptr_next];
        end
      end
    end
  end

  assign bus.out_valid = out_valid_reg;
  assign bus.out_a     = out_a_reg;
  assign bus.out_b     = out_b_reg;
  assign bus.out_d     = out_d_reg;

`ifdef CONF_INT_MAC_SEQ_STATS_EN
  logic [15:0] issue_cnt_reg, rslt_cnt_reg;

  // Free-running wrap-around statistics counters
  always_ff @(posedge clk or negedge racc) begin
    if (!racc) begin
      issue_cnt_reg <= '0;
      rslt_cnt_reg  <= '0;
    end else begin
      if (issue) issue_cnt_reg <= issue_cnt_reg + 16'd1;
      if (pop)   rslt_cnt_reg  <= rslt_cnt_reg + 16'd1;
    end
  end

  assign issue_cnt = issue_cnt_reg;
  assign rslt_cnt  = rslt_cnt_reg;
`else
  assign issue_cnt = '0;
  assign rslt_cnt  = '0;
`endif

endmodule

// File: tb/tb_conf_int_mac_pair_sequencer.sv
// Directed bench for conf_int_mac_pair_sequencer.
// dut0: MAC_LAT=0 with a combinational stub MAC d = 3*a + b.
// dut2: MAC_LAT=2 with a two-register stub MAC d = a + b.
// Counter expectations follow CONF_INT_MAC_SEQ_STATS_EN.
`timescale 1ns/1ps
module tb_conf_int_mac_pair_sequencer;
  localparam int DW = 32;
`ifdef CONF_INT_MAC_SEQ_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk  = 1'b0;
  logic racc = 1'b0;
  always #5 clk = ~clk;

  conf_int_mac_pair_sequencer_if #(.DATA_W(DW)) b0 ();
  conf_int_mac_pair_sequencer_if #(.DATA_W(DW)) b2 ();

  logic [DW-1:0] mac0_a, mac0_b, mac0_d;
  logic [DW-1:0] mac2_a, mac2_b, mac2_d;
  logic [DW-1:0] stub_r1, stub_r2;
  logic [15:0]   issue0, rslt0, issue2, rslt2;

  int tests = 0;
  int fails = 0;

  conf_int_mac_pair_sequencer #(.DATA_W(DW), .MAC_LAT(0), .FIFO_DEPTH(4)) dut0 (
    .clk(clk), .racc(racc), .bus(b0),
    .mac_a(mac0_a), .mac_b(mac0_b), .mac_d(mac0_d),
    .issue_cnt(issue0), .rslt_cnt(rslt0)
  );

  conf_int_mac_pair_sequencer #(.DATA_W(DW), .MAC_LAT(2), .FIFO_DEPTH(4)) dut2 (
    .clk(clk), .racc(racc), .bus(b2),
    .mac_a(mac2_a), .mac_b(mac2_b), .mac_d(mac2_d),
    .issue_cnt(issue2), .rslt_cnt(rslt2)
  );

  assign mac0_d = mac0_a * 32'd3 + mac0_b;

  // Two-cycle stub MAC for the latency test
  always_ff @(posedge clk or negedge racc) begin
    if (!racc) begin
      stub_r1 <= '0;
      stub_r2 <= '0;
    end else begin
      stub_r1 <= mac2_a + mac2_b;
      stub_r2 <= stub_r1;
    end
  end
  assign mac2_d = stub_r2;

  function automatic logic [31:0] model_d(input logic [31:0] a, input logic [31:0] b);
    return a * 32'd3 + b;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one word to dut0 and wait (bounded) until it is accepted
  task automatic send0(input logic [31:0] data);
    int n;
    n = 0;
    b0.in_valid = 1'b1;
    b0.in_data  = data;
    while (!b0.in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!b0.in_ready) begin
      check("send0_timeout_in_ready", 32'(b0.in_ready), 32'd1);
      b0.in_valid = 1'b0;
    end else begin
      tick();
      b0.in_valid = 1'b0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  idx;
    bit  acc;
    b0.in_valid = 1'b0; b0.in_data = '0; b0.out_ready = 1'b0;
    b2.in_valid = 1'b0; b2.in_data = '0; b2.out_ready = 1'b0;

    // Reset state
    #12;
    check("rst_in_ready", 32'(b0.in_ready), 32'd0);
    check("rst_out_valid", 32'(b0.out_valid), 32'd0);
    check("rst_mac_a", mac0_a, 32'd0);
    check("rst_out_a", b0.out_a, 32'd0);
    check("rst_issue_cnt", 32'(issue0), 32'd0);
    #10 racc = 1'b1;
    tick();
    check("idle_in_ready", 32'(b0.in_ready), 32'd1);

    // T1 single pair
    b0.out_ready = 1'b1;
    send0(32'h3);
    send0(32'h5);
    check("t1_mac_a", mac0_a, 32'h3);
    check("t1_mac_b", mac0_b, 32'h5);
    check("t1_valid_early", 32'(b0.out_valid), 32'd0);
    tick();
    check("t1_out_valid", 32'(b0.out_valid), 32'd1);
    check("t1_out_a", b0.out_a, 32'h3);
    check("t1_out_b", b0.out_b, 32'h5);
    check("t1_out_d", b0.out_d, 32'd14);
    tick();
    check("t1_empty", 32'(b0.out_valid), 32'd0);
    check("t1_hold_a", b0.out_a, 32'h3);
    check("t1_issue_cnt", 32'(issue0), STATS ? 32'd1 : 32'd0);
    check("t1_rslt_cnt", 32'(rslt0), STATS ? 32'd1 : 32'd0);

    // T2 backpressure: 4 records fill the FIFO, 5th b word stalls
    b0.out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      send0(32'h100 + k);
      send0(32'h200 + k);
    end
    send0(32'h104);
    b0.in_valid = 1'b1;
    b0.in_data  = 32'h204;
    tick();
    tick();
    check("t2_stall_in_ready", 32'(b0.in_ready), 32'd0);
    check("t2_head_a", b0.out_a, 32'h100);
    check("t2_mac_a_held", mac0_a, 32'h103);
    b0.out_ready = 1'b1;
    idx = 0;
    for (int c = 0; c < 40 && idx < 5; c++) begin
      if (b0.out_valid) begin
        check($sformatf("t2_rec%0d_a", idx), b0.out_a, 32'h100 + 32'(idx));
        check($sformatf("t2_rec%0d_b", idx), b0.out_b, 32'h200 + 32'(idx));
        check($sformatf("t2_rec%0d_d", idx), b0.out_d,
              model_d(32'h100 + 32'(idx), 32'h200 + 32'(idx)));
        idx++;
      end
      acc = b0.in_valid && b0.in_ready;
      tick();
      if (acc) b0.in_valid = 1'b0;
    end
    check("t2_drained", 32'(idx), 32'd5);
    check("t2_mac_b_last", mac0_b, 32'h204);
    check("t2_empty", 32'(b0.out_valid), 32'd0);

    // T5 push and pop on the same edge with two records queued
    b0.out_ready = 1'b0;
    send0(32'h300); send0(32'h400);
    send0(32'h301); send0(32'h401);
    send0(32'h302); send0(32'h402);
    b0.out_ready = 1'b1;
    tick();
    b0.out_ready = 1'b0;
    check("t5_valid", 32'(b0.out_valid), 32'd1);
    check("t5_head_a", b0.out_a, 32'h301);
    check("t5_head_d", b0.out_d, model_d(32'h301, 32'h401));
    b0.out_ready = 1'b1;
    tick();
    check("t5_second_valid", 32'(b0.out_valid), 32'd1);
    check("t5_second_a", b0.out_a, 32'h302);
    check("t5_second_b", b0.out_b, 32'h402);
    tick();
    check("t5_empty", 32'(b0.out_valid), 32'd0);
    b0.out_ready = 1'b0;

    // T3 latency on dut2: (7, 9) -> 16, captured at edge N+3
    b2.out_ready = 1'b1;
    check("t3_in_ready", 32'(b2.in_ready), 32'd1);
    b2.in_valid = 1'b1;
    b2.in_data  = 32'd7;
    tick();
    b2.in_data  = 32'd9;
    check("t3_b_ready", 32'(b2.in_ready), 32'd1);
    tick();
    b2.in_valid = 1'b0;
    check("t3_mac_a", mac2_a, 32'd7);
    tick();
    check("t3_valid_n1", 32'(b2.out_valid), 32'd0);
    tick();
    check("t3_valid_n2", 32'(b2.out_valid), 32'd0);
    tick();
    check("t3_valid_n3", 32'(b2.out_valid), 32'd1);
    check("t3_out_d", b2.out_d, 32'd16);
    check("t3_out_b", b2.out_b, 32'd9);

    // T4 reset mid-stream with 2 records queued and an a word held
    send0(32'h500); send0(32'h600);
    send0(32'h501); send0(32'h601);
    send0(32'h502);
    check("t4_pre_valid", 32'(b0.out_valid), 32'd1);
    racc = 1'b0;
    #1;
    check("t4_rst_valid", 32'(b0.out_valid), 32'd0);
    check("t4_rst_mac_a", mac0_a, 32'd0);
    check("t4_rst_in_ready", 32'(b0.in_ready), 32'd0);
    check("t4_rst_issue_cnt", 32'(issue0), 32'd0);
    #3 racc = 1'b1;
    tick();
    check("t4_no_stale", 32'(b0.out_valid), 32'd0);
    b0.out_ready = 1'b1;
    send0(32'h55);
    send0(32'h66);
    tick();
    check("t4_new_valid", 32'(b0.out_valid), 32'd1);
    check("t4_new_a", b0.out_a, 32'h55);
    check("t4_new_b", b0.out_b, 32'h66);
    check("t4_new_d", b0.out_d, model_d(32'h55, 32'h66));

    // T6 stats: 500 pairs streamed and popped after a fresh reset
    racc = 1'b0;
    #2 racc = 1'b1;
    tick();
    b0.out_ready = 1'b1;
    for (int i = 0; i < 500; i++) begin
      send0(32'h1000 + 32'(i));
      send0(32'h2000 + 32'(i));
    end
    tick();
    tick();
    tick();
    check("t6_empty", 32'(b0.out_valid), 32'd0);
    check("t6_last_a", b0.out_a, 32'h1000 + 32'd499);
    check("t6_issue_cnt", 32'(issue0), STATS ? 32'd500 : 32'd0);
    check("t6_rslt_cnt", 32'(rslt0), STATS ? 32'd500 : 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
